tdm_slot_scheduler: RTL and testbench

- Scheduler and arbiter for the shared 4-input, 2-bit TDM channel; decides which requester owns the output in each slot.
- Two modes:
  - Fixed TDM: strict slot order 0-1-2-3, every slot consumed.
  - Work-conserving: round-robin among active requesters only.
- Sits between four requester sources and the downstream serial consumer; slot enables and mode are configured at run time.

---
 rtl/tdm_slot_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_tdm_slot_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_scheduler.sv
// Slot scheduler/arbiter for a shared 4-input TDM channel: fixed slot order or work-conserving round-robin.
// Optional fixed-mode drop counter (drop_cnt port) is built when TDM_DROP_CNT_EN is defined.

module tdm_slot_lane #(
   parameter int DW = 2
) (
   input  logic          req,
   input  logic          en,
   input  logic          sel,
   input  logic [DW-1:0] din,
   output logic          elig,
   output logic [DW-1:0] dout
);
   assign elig = req & en;
   assign dout = sel ? din : '0;
endmodule

module tdm_slot_scheduler #(
   parameter int DW          = 2,
   parameter int HOLD_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] in0,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in2,
   input  logic [DW-1:0] in3,
   input  logic          cfg_load,
   input  logic [3:0]    cfg_slot_en,
   input  logic          cfg_mode,
   output logic [DW-1:0] out,
   output logic          out_valid,
   output logic [3:0]    grant,
   output logic [1:0]    ch_id,
   output logic          frame_start
`ifdef TDM_DROP_CNT_EN
   ,
   output logic [7:0]    drop_cnt
`endif
);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t              state, state_nxt;
   logic                mode, mode_nxt;
   logic [3:0]          slot_en, slot_en_nxt;
   logic                pend_mode, pend_mode_nxt;
   logic [3:0]          pend_en, pend_en_nxt;
   logic                pend_vld, pend_vld_nxt;
   logic [1:0]          ptr, ptr_nxt;
   logic [1:0]          last_served, last_nxt;
   logic [HW-1:0]       hold_cnt, hold_nxt;
   logic [DW-1:0]       out_nxt;
   logic                vld_nxt;
   logic [3:0]          grant_nxt;
   logic [1:0]          ch_nxt;
   logic                fs_nxt;

   logic [3:0][DW-1:0]  din, dout_l;
   logic [3:0]          elig, sel_oh;
   logic [DW-1:0]       sel_data;
   logic                boundary, apply, mode_chg, eff_mode;
   logic [3:0]          eff_en;
   logic [1:0]          eff_ptr, eff_last, idx, win, sel_idx;
   logic                win_found, slot_hit;

   assign din = {in3, in2, in1, in0};

   // hold_cnt==0 marks a slot/arbitration edge; pending config lands only there
   always_comb begin
      boundary = (hold_cnt == '0);
      apply    = boundary & pend_vld & (mode | (ptr == 2'd0));
      mode_chg = apply & (pend_mode != mode);
      eff_mode = apply ? pend_mode : mode;
      eff_en   = apply ? pend_en : slot_en;
      eff_ptr  = mode_chg ? 2'd0 : ptr;
      eff_last = mode_chg ? 2'd3 : last_served;
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      tdm_slot_lane #(.DW(DW)) u_lane (
         .req  (req[i]),
         .en   (eff_en[i]),
         .sel  (sel_oh[i]),
         .din  (din[i]),
         .elig (elig[i]),
         .dout (dout_l[i])
      );
   end

   // round-robin search starting just after the last served channel
   always_comb begin
      win_found = 1'b0;
      win       = eff_last;
      idx       = eff_last;
      for (int k = 1; k <= 4; k++) begin
         idx = eff_last + 2'(k);
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win       = idx;
         end
      end
   end

   always_comb begin
      sel_idx  = eff_mode ? win : eff_ptr;
      sel_oh   = 4'b0001 << sel_idx;
      slot_hit = eff_mode ? win_found : elig[eff_ptr];
      sel_data = '0;
      for (int i = 0; i < 4; i++) sel_data = sel_data | dout_l[i];
   end

   always_comb begin
      state_nxt     = state;
      mode_nxt      = mode;
      slot_en_nxt   = slot_en;
      pend_mode_nxt = pend_mode;
      pend_en_nxt   = pend_en;
      pend_vld_nxt  = pend_vld;
      ptr_nxt       = ptr;
      last_nxt      = last_served;
      hold_nxt      = hold_cnt;
      out_nxt       = out;
      vld_nxt       = out_valid;
      grant_nxt     = 4'b0000;
      ch_nxt        = ch_id;
      fs_nxt        = 1'b0;

      if (!boundary) begin
         hold_nxt = hold_cnt - HW'(1);
      end else begin
         if (apply) begin
            mode_nxt     = pend_mode;
            slot_en_nxt  = pend_en;
            pend_vld_nxt = 1'b0;
            ptr_nxt      = eff_ptr;
            last_nxt     = eff_last;
         end
         if (!eff_mode) begin
            // fixed: the slot is consumed whether or not it is used
            state_nxt = SERVE;
            hold_nxt  = HOLD_LAST;
            ch_nxt    = eff_ptr;
            fs_nxt    = (eff_ptr == 2'd0);
            ptr_nxt   = eff_ptr + 2'd1;
            vld_nxt   = slot_hit;
            if (slot_hit) begin
               out_nxt   = sel_data;
               grant_nxt = sel_oh;
            end
         end else if (slot_hit) begin
            state_nxt = SERVE;
            hold_nxt  = HOLD_LAST;
            out_nxt   = sel_data;
            vld_nxt   = 1'b1;
            grant_nxt = sel_oh;
            ch_nxt    = win;
            last_nxt  = win;
         end else begin
            state_nxt = IDLE;
            hold_nxt  = '0;
            vld_nxt   = 1'b0;
         end
      end

      // a load coinciding with an apply survives for the next boundary
      if (cfg_load) begin
         pend_en_nxt   = cfg_slot_en;
         pend_mode_nxt = cfg_mode;
         pend_vld_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         mode        <= 1'b0;
         slot_en     <= 4'b1111;
         pend_mode   <= 1'b0;
         pend_en     <= 4'b1111;
         pend_vld    <= 1'b0;
         ptr         <= 2'd0;
         last_served <= 2'd3;
         hold_cnt    <= '0;
         out         <= '0;
         out_valid   <= 1'b0;
         grant       <= 4'b0000;
         ch_id       <= 2'd0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         mode        <= mode_nxt;
         slot_en     <= slot_en_nxt;
         pend_mode   <= pend_mode_nxt;
         pend_en     <= pend_en_nxt;
         pend_vld    <= pend_vld_nxt;
         ptr         <= ptr_nxt;
         last_served <= last_nxt;
         hold_cnt    <= hold_nxt;
         out         <= out_nxt;
         out_valid   <= vld_nxt;
         grant       <= grant_nxt;
         ch_id       <= ch_nxt;
         frame_start <= fs_nxt;
      end
   end

`ifdef TDM_DROP_CNT_EN
   logic [7:0] drop_q;

   // counts enabled fixed-mode slots that found no request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         drop_q <= 8'd0;
      else if (apply)
         drop_q <= 8'd0;
      else if (boundary && !eff_mode && eff_en[eff_ptr] && !req[eff_ptr] && (drop_q != 8'hFF))
         drop_q <= drop_q + 8'd1;
   end

   assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Bench for tdm_slot_scheduler: vector table, corner sequences and a random run against a slot-level model.
// Two instances (HOLD_CYCLES=1 and 3) share all inputs; drop_cnt checks follow TDM_DROP_CNT_EN.

module tb_tdm_slot_scheduler;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [1:0] in0, in1, in2, in3;
   logic       cfg_load;
   logic [3:0] cfg_slot_en;
   logic       cfg_mode;
   logic [1:0] out1, out3, ch1, ch3;
   logic       vld1, vld3, fs1, fs3;
   logic [3:0] g1, g3;
`ifdef TDM_DROP_CNT_EN
   logic [7:0] drop1, drop3;
`endif

   int total = 0;
   int bad   = 0;
   bit mchk  = 0;

   always #5 clk = ~clk;

   tdm_slot_scheduler #(.DW(2), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .cfg_load(cfg_load), .cfg_slot_en(cfg_slot_en), .cfg_mode(cfg_mode),
      .out(out1), .out_valid(vld1), .grant(g1), .ch_id(ch1), .frame_start(fs1)
`ifdef TDM_DROP_CNT_EN
      , .drop_cnt(drop1)
`endif
   );

   tdm_slot_scheduler #(.DW(2), .HOLD_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .cfg_load(cfg_load), .cfg_slot_en(cfg_slot_en), .cfg_mode(cfg_mode),
      .out(out3), .out_valid(vld3), .grant(g3), .ch_id(ch3), .frame_start(fs3)
`ifdef TDM_DROP_CNT_EN
      , .drop_cnt(drop3)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ev(int o, int v, int g, int c, int f);
      return {22'd0, 2'(o), 1'(v), 4'(g), 2'(c), 1'(f)};
   endfunction

   // ---------------- slot-level reference model ----------------
   typedef struct {
      int mode, mask, pmode, pmask, pvld;
      int ptr, last, elapsed;
      int out, vld, grant, ch, fs, drop;
   } ms_t;

   function automatic ms_t m_reset(int hold);
      ms_t s;
      s.mode = 0; s.mask = 15; s.pmode = 0; s.pmask = 15; s.pvld = 0;
      s.ptr = 0; s.last = 3; s.elapsed = hold;
      s.out = 0; s.vld = 0; s.grant = 0; s.ch = 0; s.fs = 0; s.drop = 0;
      return s;
   endfunction

   function automatic ms_t m_step(ms_t s, int hold, logic [3:0] rq, int d0, int d1, int d2, int d3,
                                  logic ld, logic [3:0] len, logic lm);
      ms_t n;
      int  d[4];
      int  p, w, c;
      bit  applies;
      n = s;
      d = '{d0, d1, d2, d3};
      n.grant = 0;
      n.fs    = 0;
      if (s.elapsed < hold) begin
         n.elapsed = s.elapsed + 1;
      end else begin
         applies = (s.pvld != 0) && (s.mode == 1 || s.ptr == 0);
         if (applies) begin
            n.mode = s.pmode; n.mask = s.pmask; n.pvld = 0; n.drop = 0;
            if (s.pmode != s.mode) begin n.ptr = 0; n.last = 3; end
         end
         if (n.mode == 0) begin
            p = n.ptr;
            n.ch = p; n.fs = (p == 0); n.elapsed = 1; n.ptr = (p + 1) % 4;
            if (((n.mask >> p) & 1) != 0 && rq[p]) begin
               n.out = d[p]; n.vld = 1; n.grant = 1 << p;
            end else begin
               n.vld = 0;
               if (((n.mask >> p) & 1) != 0 && !applies && n.drop < 255) n.drop++;
            end
         end else begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
               c = (n.last + k) % 4;
               if (w < 0 && ((n.mask >> c) & 1) != 0 && rq[c]) w = c;
            end
            if (w >= 0) begin
               n.out = d[w]; n.vld = 1; n.grant = 1 << w; n.ch = w; n.last = w; n.elapsed = 1;
            end else begin
               n.vld = 0; n.elapsed = hold;
            end
         end
      end
      if (ld) begin n.pmask = len; n.pmode = lm; n.pvld = 1; end
      return n;
   endfunction

   ms_t m1, m3;

   always begin
      @(posedge clk);
      if (!rst) begin
         m1 = m_reset(1);
         m3 = m_reset(3);
      end else begin
         m1 = m_step(m1, 1, req, in0, in1, in2, in3, cfg_load, cfg_slot_en, cfg_mode);
         m3 = m_step(m3, 3, req, in0, in1, in2, in3, cfg_load, cfg_slot_en, cfg_mode);
      end
      #1;
      if (mchk) begin
         chk("model_h1", {22'd0, out1, vld1, g1, ch1, fs1}, ev(m1.out, m1.vld, m1.grant, m1.ch, m1.fs));
         chk("model_h3", {22'd0, out3, vld3, g3, ch3, fs3}, ev(m3.out, m3.vld, m3.grant, m3.ch, m3.fs));
`ifdef TDM_DROP_CNT_EN
         chk("model_drop_h1", {24'd0, drop1}, 32'(m1.drop));
         chk("model_drop_h3", {24'd0, drop3}, 32'(m3.drop));
`endif
      end
   end

   // ---------------- directed vectors for the HOLD_CYCLES=1 instance ----------------
   typedef struct {
      logic [3:0]  rq;
      logic        ld;
      logic [3:0]  len;
      logic        lm;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[28];

   initial begin
      int t_first, t_second, seen;
      tbl[0]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(0,1,1,0,1)};
      tbl[1]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(1,1,2,1,0)};
      tbl[2]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(2,1,4,2,0)};
      tbl[3]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(3,1,8,3,0)};
      tbl[4]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(0,1,1,0,1)};
      tbl[5]  = '{4'hF, 1'b1, 4'h5, 1'b0, ev(1,1,2,1,0)};
      tbl[6]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(2,1,4,2,0)};
      tbl[7]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(3,1,8,3,0)};
      tbl[8]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(0,1,1,0,1)};
      tbl[9]  = '{4'hF, 1'b0, 4'h0, 1'b0, ev(0,0,0,1,0)};
      tbl[10] = '{4'hF, 1'b0, 4'h0, 1'b0, ev(2,1,4,2,0)};
      tbl[11] = '{4'hF, 1'b0, 4'h0, 1'b0, ev(2,0,0,3,0)};
      tbl[12] = '{4'hF, 1'b0, 4'h0, 1'b0, ev(0,1,1,0,1)};
      tbl[13] = '{4'hA, 1'b1, 4'hF, 1'b1, ev(0,0,0,1,0)};
      tbl[14] = '{4'hA, 1'b0, 4'h0, 1'b0, ev(0,0,0,2,0)};
      tbl[15] = '{4'hA, 1'b0, 4'h0, 1'b0, ev(0,0,0,3,0)};
      tbl[16] = '{4'hA, 1'b0, 4'h0, 1'b0, ev(1,1,2,1,0)};
      tbl[17] = '{4'hA, 1'b0, 4'h0, 1'b0, ev(3,1,8,3,0)};
      tbl[18] = '{4'hA, 1'b0, 4'h0, 1'b0, ev(1,1,2,1,0)};
      tbl[19] = '{4'hA, 1'b0, 4'h0, 1'b0, ev(3,1,8,3,0)};
      tbl[20] = '{4'h0, 1'b0, 4'h0, 1'b0, ev(3,0,0,3,0)};
      tbl[21] = '{4'h0, 1'b0, 4'h0, 1'b0, ev(3,0,0,3,0)};
      tbl[22] = '{4'h4, 1'b0, 4'h0, 1'b0, ev(2,1,4,2,0)};
      tbl[23] = '{4'h4, 1'b0, 4'h0, 1'b0, ev(2,1,4,2,0)};
      tbl[24] = '{4'h4, 1'b0, 4'h0, 1'b0, ev(2,1,4,2,0)};
      tbl[25] = '{4'hF, 1'b1, 4'hF, 1'b0, ev(3,1,8,3,0)};
      tbl[26] = '{4'hF, 1'b0, 4'h0, 1'b0, ev(0,1,1,0,1)};
      tbl[27] = '{4'hF, 1'b0, 4'h0, 1'b0, ev(1,1,2,1,0)};

      rst = 1'b0; req = 4'h0; cfg_load = 1'b0; cfg_slot_en = 4'h0; cfg_mode = 1'b0;
      in0 = 2'd0; in1 = 2'd1; in2 = 2'd2; in3 = 2'd3;
      tick(); tick();
      chk("reset_h1", {22'd0, out1, vld1, g1, ch1, fs1}, 32'd0);
      chk("reset_h3", {22'd0, out3, vld3, g3, ch3, fs3}, 32'd0);
      mchk = 1;
      req = 4'hF;
      #2 rst = 1'b1;

      for (int r = 0; r < 28; r++) begin
         req = tbl[r].rq; cfg_load = tbl[r].ld; cfg_slot_en = tbl[r].len; cfg_mode = tbl[r].lm;
         tick();
         chk($sformatf("vec%0d", r), {22'd0, out1, vld1, g1, ch1, fs1}, tbl[r].exp);
      end
      cfg_load = 1'b0;

      // reset asserted mid-slot after a work-conserving config was applied
      #2 rst = 1'b0;
      tick();
      #2 rst = 1'b1;
      req = 4'hF;
      for (int t = 1; t <= 8; t++) begin
         cfg_load = (t == 2); cfg_slot_en = 4'h3; cfg_mode = 1'b1;
         tick();
      end
      cfg_load = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async_rst_h1", {22'd0, out1, vld1, g1, ch1, fs1}, 32'd0);
      chk("async_rst_h3", {22'd0, out3, vld3, g3, ch3, fs3}, 32'd0);
      tick();
      #2 rst = 1'b1;

      // after release: fixed mode, full mask, slot 0 first; HOLD=3 holds each value
      t_first = -1; t_second = -1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (t == 1) chk("post_rst_slot0_h1", {22'd0, out1, vld1, g1, ch1, fs1}, ev(0,1,1,0,1));
         if (t == 3) chk("hold3_mid", {22'd0, out3, vld3, g3, ch3, fs3}, ev(0,1,0,0,0));
         if (t == 4) chk("hold3_slot1", {22'd0, out3, vld3, g3, ch3, fs3}, ev(1,1,2,1,0));
         if (fs3) begin
            if (t_first < 0) t_first = t;
            else if (t_second < 0) t_second = t;
         end
      end
      chk("fs_found_h3", {31'd0, (t_second > 0)}, 32'd1);
      chk("fs_spacing_h3", 32'(t_second - t_first), 32'd12);

      // empty mask in fixed mode: frame keeps running, nothing valid
      cfg_load = 1'b1; cfg_slot_en = 4'h0; cfg_mode = 1'b0;
      tick();
      cfg_load = 1'b0;
      for (int t = 0; t < 5; t++) tick();
      seen = 0;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("en0_vld_h1", {31'd0, vld1}, 32'd0);
         if (fs1) seen++;
      end
      chk("en0_frame_h1", 32'(seen), 32'd1);

`ifdef TDM_DROP_CNT_EN
      #2 rst = 1'b0;
      tick();
      #2 rst = 1'b1;
      req = 4'h1;
      for (int t = 0; t < 400; t++) tick();
      chk("drop_sat_h1", {24'd0, drop1}, 32'd255);
      cfg_load = 1'b1; cfg_slot_en = 4'hF; cfg_mode = 1'b0;
      tick();
      cfg_load = 1'b0;
      seen = 0;
      for (int t = 0; t < 8 && seen == 0; t++) begin
         tick();
         if (fs1) seen = 1;
      end
      chk("drop_apply_seen", 32'(seen), 32'd1);
      chk("drop_clear_h1", {24'd0, drop1}, 32'd0);
`endif

      // randomized traffic and config checked against the model
      for (int t = 0; t < 2000; t++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         in0 = 2'($urandom); in1 = 2'($urandom); in2 = 2'($urandom); in3 = 2'($urandom);
         cfg_load    = ($urandom_range(0, 19) == 0);
         cfg_slot_en = 4'($urandom);
         cfg_mode    = 1'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
